// File: rtl/div4_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// using an invert/increment/add trial subtraction and a start/busy/done handshake.
module div4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [3:0]  d_q;
  logic [3:0]  q_q;
  logic [4:0]  r_q;
  logic [1:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;
  logic [3:0]  quo_q;
  logic [3:0]  rem_q;

  logic [4:0]  r_d;
  logic [3:0]  q_d;

  // One restoring iteration; bit 5 of the 6-bit sum is the carry-out (no borrow).
  function automatic logic [8:0] trial_step(input logic [4:0] r, input logic [3:0] q,
                                            input logic [3:0] d);
    logic [4:0] r_sh;
    logic [3:0] q_sh;
    logic [5:0] sum;
    r_sh = {r[3:0], q[3]};
    q_sh = {q[2:0], 1'b0};
    sum  = {1'b0, r_sh} + {1'b0, ~{1'b0, d}} + 6'd1;
    if (sum[5]) trial_step = {sum[4:0], q_sh[3:1], 1'b1};
    else        trial_step = {r_sh, q_sh[3:1], 1'b0};
  endfunction

  always_comb begin
    {r_d, q_d} = trial_step(r_q, q_q, d_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= 4'd0;
      q_q     <= 4'd0;
      r_q     <= 5'd0;
      cnt_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= 4'd0;
      rem_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor == 4'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= 4'hF;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              d_q     <= divisor;
              q_q     <= dividend;
              r_q     <= 5'd0;
              cnt_q   <= 2'd0;
              dz_q    <= 1'b0;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= q_d;
            rem_q   <= r_d[3:0];
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq: directed table, exhaustive and random
// sweeps against an arithmetic model, plus handshake/reset/hold sequences.
module tb_div4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_cmp = 0;
  int n_err = 0;

  div4_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
    int         bcnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference, divide-by-zero convention included.
  task automatic model(input int a, input int b, output logic [3:0] q,
                       output logic [3:0] r, output logic dz);
    if (b == 0) begin
      q = 4'hF; r = a[3:0]; dz = 1'b1;
    end else begin
      q = 4'(a / b); r = 4'(a % b); dz = 1'b0;
    end
  endtask

  // Launch one division from IDLE and check results, latency and busy count.
  // lat = edges after the accepting edge until done is seen; bcnt = busy samples before done.
  task automatic check_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input int elat, input int ebcnt);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    @(negedge clk);
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      bcnt += int'(busy);
      @(negedge clk);
      lat++;
    end
    chk({name, " done_seen"}, done, 1'b1);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_zero"}, div_zero, edz);
    chk({name, " latency"}, lat, elat);
    chk({name, " busy_cycles"}, bcnt, ebcnt);
    chk({name, " busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    chk({name, " done_pulse_width"}, done, 1'b0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, " busy"}, busy, 1'b0);
    chk({name, " done"}, done, 1'b0);
    chk({name, " quotient"}, quotient, 4'd0);
    chk({name, " remainder"}, remainder, 4'd0);
    chk({name, " div_zero"}, div_zero, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [3:0] mq, mr;
    logic       mdz;
    int         seen_done;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4, 4};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4, 4};
    vecs[2] = '{4'd5,  4'd7,  4'd0,  4'd5, 1'b0, 4, 4};
    vecs[3] = '{4'd0,  4'd9,  4'd0,  4'd0, 1'b0, 4, 4};
    vecs[4] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 0, 0};
    vecs[5] = '{4'd6,  4'd2,  4'd3,  4'd0, 1'b0, 4, 4};
    vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4, 4};
    vecs[7] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0, 4, 4};
    vecs[8] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 0, 0};

    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
               vecs[i].dz, vecs[i].lat, vecs[i].bcnt);

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        model(a, b, mq, mr, mdz);
        check_op($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), mq, mr, mdz, 4, 4);
      end

    for (int k = 0; k < 40; k++) begin
      int a, b;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      model(a, b, mq, mr, mdz);
      check_op($sformatf("rand %0d/%0d", a, b), 4'(a), 4'(b), mq, mr, mdz,
               (b == 0) ? 0 : 4, (b == 0) ? 0 : 4);
    end

    // start held high: accepts every 6th edge, operands scrambled in between
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      start = 1'b1;
      if (k % 6 == 0) begin
        dividend = 4'd11; divisor = 4'd2;
      end else begin
        dividend = 4'($urandom); divisor = 4'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("held k=%0d done", k), done, (k % 6 == 4));
      chk($sformatf("held k=%0d busy", k), busy, (k % 6 < 4));
      if (k % 6 == 4) begin
        chk($sformatf("held k=%0d quotient", k), quotient, 4'd5);
        chk($sformatf("held k=%0d remainder", k), remainder, 4'd1);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of CALC
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      seen_done += int'(done);
    end
    chk("no_done_after_abort", seen_done, 0);
    chk("idle_after_abort busy", busy, 1'b0);
    check_op("post_reset 14/4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 4, 4);

    // results hold while idle with changing operands
    check_op("hold_setup 7/0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      dividend = 4'($urandom); divisor = 4'($urandom);
      @(negedge clk);
      chk($sformatf("hold%0d quotient", k), quotient, 4'hF);
      chk($sformatf("hold%0d remainder", k), remainder, 4'd7);
      chk($sformatf("hold%0d div_zero", k), div_zero, 1'b1);
    end
    check_op("dz_clear 6/2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
